// File: rtl/serial_alu_pkg.sv
// Shared definitions for the sequential ALU blocks: state encoding, default width
// and a constant-evaluable ceil(log2) for sizing counters.
package serial_alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_4bit_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_FLAG_EN is defined.
interface serial_adder_4bit_if #(
    parameter int unsigned WIDTH = serial_alu_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             c0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             c_out;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
    logic             ovf;

    modport master (output start, A, B, c0, input busy, done, S, c_out, ovf);
    modport slave  (input start, A, B, c0, output busy, done, S, c_out, ovf);
`else
    modport master (output start, A, B, c0, input busy, done, S, c_out);
    modport slave  (input start, A, B, c0, output busy, done, S, c_out);
`endif
endinterface

// File: rtl/full_adder_1bit.sv
// Single combinational full-adder cell shared by the serial datapath.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial ripple-carry adder: S = A + B + c0, one bit per cycle LSB-first.
// Optional signed-overflow output under SERIAL_ADDER_OVF_FLAG_EN.
module serial_adder_4bit
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_4bit_if.slave  sa
);
    localparam int unsigned CW = clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic [WIDTH-1:0] w_s_nxt;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_sum_bit;
    logic             w_cout;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_S;
    logic             r_c_out;

    full_adder_1bit u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_sum_bit),
        .cout (w_cout)
    );

    assign w_s_nxt = {w_sum_bit, r_s_sh[WIDTH-1:1]};

    // Next state; start is honoured only in IDLE or DONE
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = (r_cnt == CW'(WIDTH - 1));
        case (r_state)
            IDLE: begin
                if (sa.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                if (sa.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Serial datapath; result registers only update on the final bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_S     <= '0;
            r_c_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= sa.A;
            r_b_sh  <= sa.B;
            r_carry <= sa.c0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_s_sh  <= w_s_nxt;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_S     <= w_s_nxt;
                r_c_out <= w_cout;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_FLAG_EN
    logic r_ovf;

    // On the last bit r_carry is the carry into the MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (!w_accept && r_state == RUN && w_last) begin
            r_ovf <= r_carry ^ w_cout;
        end
    end

    assign sa.ovf = r_ovf;
`endif

    assign sa.busy  = r_busy;
    assign sa.done  = r_done;
    assign sa.S     = r_S;
    assign sa.c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Randomised and directed bench for serial_adder_4bit against an arithmetic model.
module tb_serial_adder_4bit;
    localparam int unsigned WIDTH = 4;
    localparam int HALF = 1 << (WIDTH - 1);
    localparam int FULL = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_adder_4bit_if #(.WIDTH(WIDTH)) sa ();
    serial_adder_4bit #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .sa(sa));

    int n_total = 0;
    int n_bad   = 0;
    logic [WIDTH-1:0] prev_s;
    logic             prev_c;
    logic             prev_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {signed_overflow, carry_out, sum}
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic c);
        int unsigned u;
        int sa_v, sb_v, ss;
        logic v;
        u    = int'(a) + int'(b) + int'(c);
        sa_v = a[WIDTH-1] ? int'(a) - FULL : int'(a);
        sb_v = b[WIDTH-1] ? int'(b) - FULL : int'(b);
        ss   = sa_v + sb_v + int'(c);
        v    = (ss > HALF - 1) || (ss < -HALF);
        return {v, u[WIDTH], u[WIDTH-1:0]};
    endfunction

    task automatic check_outputs(input string tag, input logic [WIDTH-1:0] s, input logic c, input logic v);
        check({tag, "_S"}, 32'(sa.S), 32'(s));
        check({tag, "_cout"}, 32'(sa.c_out), 32'(c));
`ifdef SERIAL_ADDER_OVF_FLAG_EN
        check({tag, "_ovf"}, 32'(sa.ovf), 32'(v));
`else
        if (v === 1'bx) check({tag, "_ovf_x"}, 32'(v), 32'd0);
`endif
    endtask

    // Drive a start pulse; returns #1 after the accepting edge with inputs scrambled
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        @(negedge clk);
        sa.start = 1'b1;
        sa.A = a;
        sa.B = b;
        sa.c0 = c;
        @(posedge clk);
        #1;
        sa.start = 1'b0;
        sa.A = WIDTH'($urandom);
        sa.B = WIDTH'($urandom);
        sa.c0 = 1'($urandom);
    endtask

    task automatic await_done(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                              input bit mid_start, input string tag);
        logic [WIDTH+1:0] exp;
        int lat;
        int busy_cnt;
        exp = ref_add(a, b, c);
        lat = 0;
        check({tag, "_busy_acc"}, 32'(sa.busy), 32'd1);
        check({tag, "_done_acc"}, 32'(sa.done), 32'd0);
        busy_cnt = int'(sa.busy);
        for (int k = 1; k <= int'(WIDTH) + 2 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (mid_start && k == 2) begin
                sa.start = 1'b1;
                sa.A = 1;
                sa.B = 1;
                sa.c0 = 1'b0;
            end
            if (mid_start && k == 3) sa.start = 1'b0;
            if (sa.done) begin
                lat = k;
            end else begin
                busy_cnt += int'(sa.busy);
                check_outputs({tag, "_hold"}, prev_s, prev_c, prev_v);
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        if (lat != 0) begin
            check({tag, "_busy_done"}, 32'(sa.busy), 32'd0);
            check_outputs({tag, "_res"}, exp[WIDTH-1:0], exp[WIDTH], exp[WIDTH+1]);
        end
        prev_s = exp[WIDTH-1:0];
        prev_c = exp[WIDTH];
        prev_v = exp[WIDTH+1];
    endtask

    task automatic post_idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check({tag, "_idle_done"}, 32'(sa.done), 32'd0);
            check({tag, "_idle_busy"}, 32'(sa.busy), 32'd0);
            check_outputs({tag, "_idle"}, prev_s, prev_c, prev_v);
        end
    endtask

    task automatic one_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input string tag);
        issue(a, b, c);
        await_done(a, b, c, 1'b0, tag);
        post_idle(2, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic rc;
        sa.start = 1'b0;
        sa.A = '0;
        sa.B = '0;
        sa.c0 = 1'b0;
        rst_n = 1'b0;
        prev_s = '0;
        prev_c = 1'b0;
        prev_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(sa.busy), 32'd0);
        check("rst_done", 32'(sa.done), 32'd0);
        check_outputs("rst", '0, 1'b0, 1'b0);
        rst_n = 1'b1;

        one_op(4'd4, 4'd5, 1'b0, "add_4_5");
        one_op(4'd15, 4'd1, 1'b0, "wrap_15_1");
        one_op(4'd7, 4'd8, 1'b1, "add_7_8_c");
        one_op(4'd7, 4'd1, 1'b0, "sovf_7_1");
        one_op(4'd0, 4'd0, 1'b0, "zero");
        one_op(4'd15, 4'd15, 1'b1, "max");

        // start during RUN must be ignored
        issue(4'd4, 4'd5, 1'b0);
        await_done(4'd4, 4'd5, 1'b0, 1'b1, "mid_start");
        post_idle(3, "mid_start");

        // start held in the DONE cycle chains straight into RUN
        issue(4'd9, 4'd9, 1'b1);
        await_done(4'd9, 4'd9, 1'b1, 1'b0, "b2b_first");
        sa.start = 1'b1;
        sa.A = 4'd3;
        sa.B = 4'd2;
        sa.c0 = 1'b0;
        @(posedge clk);
        #1;
        sa.start = 1'b0;
        sa.A = '0;
        sa.B = '0;
        await_done(4'd3, 4'd2, 1'b0, 1'b0, "b2b_second");
        post_idle(2, "b2b");

        // reset in the middle of RUN aborts without a done pulse
        issue(4'd6, 4'd7, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(sa.busy), 32'd0);
        check("abort_done", 32'(sa.done), 32'd0);
        prev_s = '0;
        prev_c = 1'b0;
        prev_v = 1'b0;
        check_outputs("abort", '0, 1'b0, 1'b0);
        post_idle(int'(WIDTH) + 2, "abort");
        one_op(4'd2, 4'd2, 1'b0, "after_abort");

        for (int i = 0; i < 30; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            issue(ra, rb, rc);
            await_done(ra, rb, rc, 1'b0, "rand");
            if ($urandom_range(0, 1) == 1) post_idle(1, "rand");
        end
        post_idle(1, "final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
